// File: rtl/spi_clk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// spi_clk_pkg : shared sizing constants and FSM encoding for spi_clk_ctrl
// Revision    : 1.0
// ============================================================================
package spi_clk_pkg;

  localparam int DIV_W   = 12;
  localparam int CNT_W   = 6;
  localparam int DIV_RST = 24;   // 1 MHz SCLK from a 50 MHz clk_i

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_TRAIL = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_clk_ctrl_if.sv
`default_nettype none
// ============================================================================
// spi_clk_ctrl_if : control/status bundle between an SPI engine and the
//                   SCLK/CS generator
// Revision        : 1.0
// ============================================================================
interface spi_clk_ctrl_if #(
  parameter int DIV_W = spi_clk_pkg::DIV_W,
  parameter int CNT_W = spi_clk_pkg::CNT_W
);

  logic [DIV_W-1:0] div_i;
  logic             cfg_we_i;
  logic [CNT_W-1:0] nbits_i;
  logic             start_i;
  logic             abort_i;
  logic             sclk_o;
  logic             cs_n_o;
  logic             fall_stb_o;
  logic             rise_stb_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output div_i, cfg_we_i, nbits_i, start_i, abort_i,
    input  sclk_o, cs_n_o, fall_stb_o, rise_stb_o, busy_o, done_o
  );

  modport slave (
    input  div_i, cfg_we_i, nbits_i, start_i, abort_i,
    output sclk_o, cs_n_o, fall_stb_o, rise_stb_o, busy_o, done_o
  );

endinterface
`default_nettype wire

// File: rtl/spi_clk_ctrl_hp_timer.sv
`default_nettype none
// ============================================================================
// hp_timer : loadable down-counter, expire_o pulses every div_i+1 cycles
// Revision : 1.0
// ============================================================================
module hp_timer #(
  parameter int DIV_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             expire_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? div_i : cnt_q - 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_clk_ctrl.sv
`default_nettype none
// ============================================================================
// spi_clk_ctrl : CPOL=1/CPHA=1 SCLK and chip-select burst generator
// Revision     : 1.0
// ============================================================================
module spi_clk_ctrl #(
  parameter int DIV_W   = spi_clk_pkg::DIV_W,
  parameter int CNT_W   = spi_clk_pkg::CNT_W,
  parameter int DIV_RST = spi_clk_pkg::DIV_RST
) (
  input  logic          clk_i,
  input  logic          rst_i,
  spi_clk_ctrl_if.slave bus
);

  import spi_clk_pkg::*;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] bits_inc;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             fall_stb_q, fall_stb_d;
  logic             rise_stb_q, rise_stb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timer_load;
  logic             timer_en;
  logic             timer_exp;

  assign timer_en = (state_q != ST_IDLE);
  assign bits_inc = bits_q + 1'b1;

  // Load uses div_d so a config write coinciding with start takes effect at once
  hp_timer #(.DIV_W(DIV_W)) u_hp_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (timer_load),
    .en_i     (timer_en),
    .div_i    (div_d),
    .expire_o (timer_exp)
  );

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    nbits_d    = nbits_q;
    bits_d     = bits_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    fall_stb_d = 1'b0;
    rise_stb_d = 1'b0;
    done_d     = 1'b0;
    timer_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_we_i) begin
          div_d = bus.div_i;
        end
        // done_q blocks a start presented in the completion cycle
        if (bus.start_i && !bus.abort_i && !done_q && (bus.nbits_i != '0)) begin
          state_d    = ST_LEAD;
          nbits_d    = bus.nbits_i;
          bits_d     = '0;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          timer_load = 1'b1;
        end
      end
      ST_LEAD: begin
        if (timer_exp) begin
          sclk_d     = 1'b0;
          fall_stb_d = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (timer_exp) begin
          if (sclk_q) begin
            sclk_d     = 1'b0;
            fall_stb_d = 1'b1;
          end else begin
            sclk_d     = 1'b1;
            rise_stb_d = 1'b1;
            bits_d     = bits_inc;
            if (bits_inc == nbits_q) begin
              state_d = ST_TRAIL;
            end
          end
        end
      end
      ST_TRAIL: begin
        if (timer_exp) begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && bus.abort_i) begin
      state_d    = ST_IDLE;
      sclk_d     = 1'b1;
      cs_n_d     = 1'b1;
      busy_d     = 1'b0;
      fall_stb_d = 1'b0;
      rise_stb_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      div_q      <= DIV_W'(DIV_RST);
      nbits_q    <= '0;
      bits_q     <= '0;
      sclk_q     <= 1'b1;
      cs_n_q     <= 1'b1;
      fall_stb_q <= 1'b0;
      rise_stb_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      nbits_q    <= nbits_d;
      bits_q     <= bits_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      fall_stb_q <= fall_stb_d;
      rise_stb_q <= rise_stb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.sclk_o     = sclk_q;
  assign bus.cs_n_o     = cs_n_q;
  assign bus.fall_stb_o = fall_stb_q;
  assign bus.rise_stb_o = rise_stb_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_clk_ctrl.sv
`default_nettype none
// ============================================================================
// tb_spi_clk_ctrl : scoreboard bench for spi_clk_ctrl strobe/done timing
// Revision        : 1.0
// ============================================================================
module tb_spi_clk_ctrl;

  localparam int EV_FALL = 0;
  localparam int EV_RISE = 1;
  localparam int EV_DONE = 2;
  localparam int NOLIM   = 100000;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];

  spi_clk_ctrl_if bus ();

  spi_clk_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected event times: fall k at 1+(2k-1)H, rise k at 1+2kH, done at 1+(2N+1)H
  function automatic void push_burst(int c0, int h, int n, int lim);
    for (int k = 1; k <= n; k++) begin
      if (1 + (2*k-1)*h <= lim) exp_q.push_back('{EV_FALL, c0 + 1 + (2*k-1)*h});
      if (1 + 2*k*h <= lim)     exp_q.push_back('{EV_RISE, c0 + 1 + 2*k*h});
    end
    if (1 + (2*n+1)*h <= lim) exp_q.push_back('{EV_DONE, c0 + 1 + (2*n+1)*h});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic score(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind=%0d at cycle %0d, required no event", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind=%0d cycle=%0d, required kind=%0d cycle=%0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.fall_stb_o === 1'b1) score(EV_FALL);
    if (bus.rise_stb_o === 1'b1) score(EV_RISE);
    if (bus.done_o === 1'b1)     score(EV_DONE);
  end

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_sclk"}, 32'(bus.sclk_o), 32'd1);
    chk({nm, "_cs_n"}, 32'(bus.cs_n_o), 32'd1);
    chk({nm, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({nm, "_done"}, 32'(bus.done_o), 32'd0);
    chk({nm, "_fall"}, 32'(bus.fall_stb_o), 32'd0);
    chk({nm, "_rise"}, 32'(bus.rise_stb_o), 32'd0);
  endtask

  task automatic cfg_div(input int d);
    bus.div_i    = 12'(d);
    bus.cfg_we_i = 1'b1;
    @(negedge clk);
    bus.cfg_we_i = 1'b0;
  endtask

  // Drives start for the current cycle; the caller releases it on the next negedge
  task automatic start_at(input int n, output int c0);
    bus.start_i = 1'b1;
    bus.nbits_i = 6'(n);
    c0 = cyc;
  endtask

  initial begin
    int c0;
    bus.div_i    = '0;
    bus.cfg_we_i = 1'b0;
    bus.nbits_i  = '0;
    bus.start_i  = 1'b0;
    bus.abort_i  = 1'b0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // div=0, N=1: cs low at 1, fall 2, rise 3, done 4
    cfg_div(0);
    start_at(1, c0);
    exp_q.push_back('{EV_FALL, c0 + 2});
    exp_q.push_back('{EV_RISE, c0 + 3});
    exp_q.push_back('{EV_DONE, c0 + 4});
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("h1_busy_c1", 32'(bus.busy_o), 32'd1);
    chk("h1_cs_n_c1", 32'(bus.cs_n_o), 32'd0);
    @(negedge clk);
    chk("h1_sclk_c2", 32'(bus.sclk_o), 32'd0);
    repeat (5) @(negedge clk);
    chk("h1_busy_end", 32'(bus.busy_o), 32'd0);
    chk("h1_cs_n_end", 32'(bus.cs_n_o), 32'd1);

    // div=24, N=8; divisor write at cycle 100 held until idle
    cfg_div(24);
    start_at(8, c0);
    push_burst(c0, 25, 8, NOLIM);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (99) @(negedge clk);
    bus.div_i    = 12'd3;
    bus.cfg_we_i = 1'b1;
    repeat (326) @(negedge clk);
    chk("h25_done_c426", 32'(bus.done_o), 32'd1);
    chk("h25_cs_n_c426", 32'(bus.cs_n_o), 32'd1);
    chk("h25_busy_c426", 32'(bus.busy_o), 32'd0);
    bus.start_i = 1'b1;
    bus.nbits_i = 6'd2;
    @(negedge clk);
    bus.cfg_we_i = 1'b0;
    chk("b2b_ignored", 32'(bus.busy_o), 32'd0);
    start_at(2, c0);
    push_burst(c0, 4, 2, NOLIM);
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("b2b_accepted", 32'(bus.busy_o), 32'd1);
    repeat (25) @(negedge clk);

    // Abort at cycle 200 of a div=24, N=8 burst
    cfg_div(24);
    start_at(8, c0);
    push_burst(c0, 25, 8, 200);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (199) @(negedge clk);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("abort_sclk", 32'(bus.sclk_o), 32'd1);
    chk("abort_cs_n", 32'(bus.cs_n_o), 32'd1);
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    repeat (300) @(negedge clk);

    // Reset at cycle 150 of a div=5 burst; divisor must return to 24
    cfg_div(5);
    start_at(20, c0);
    push_burst(c0, 6, 20, 150);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (149) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("midrst");
    @(negedge clk);
    start_at(1, c0);
    push_burst(c0, 25, 1, NOLIM);
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("postrst_busy", 32'(bus.busy_o), 32'd1);
    repeat (85) @(negedge clk);

    // Ignored starts: nbits=0, and start together with abort in idle
    start_at(0, c0);
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("nbits0_busy", 32'(bus.busy_o), 32'd0);
    bus.start_i = 1'b1;
    bus.nbits_i = 6'd4;
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    chk("start_abort_busy", 32'(bus.busy_o), 32'd0);
    chk("start_abort_cs_n", 32'(bus.cs_n_o), 32'd1);
    repeat (10) @(negedge clk);

    chk("events_pending", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_clk_ctrl.md
SPI_CLK_CTRL -- requirements
Module: spi_clk_ctrl

Interface
REQ-001 The block SHALL have exactly one clock, clk_i, and a synchronous active-high reset, rst_i; these are the only clock and reset.
REQ-002 Parameter DIV_W, default 12: width of the half-period divisor.
REQ-003 Parameter CNT_W, default 6: width of the bit-count field.
REQ-004 Parameter DIV_RST, default 24: divisor value loaded at reset (1 MHz SCLK from 50 MHz).
REQ-005 clk_i  in  1  system clock, all logic rising-edge.
REQ-006 rst_i  in  1  synchronous reset, active-high.
REQ-007 div_i  in  DIV_W  half-period length minus 1, in clk_i cycles.
REQ-008 cfg_we_i  in  1  latch div_i into the divisor register.
REQ-009 nbits_i  in  CNT_W  SCLK cycles per burst, sampled with start_i.
REQ-010 start_i  in  1  single-cycle burst request.
REQ-011 abort_i  in  1  terminate the burst immediately.
REQ-012 sclk_o  out  1  serial clock, idle high (CPOL=1, CPHA=1).
REQ-013 cs_n_o  out  1  chip select, active-low.
REQ-014 fall_stb_o  out  1  one-cycle strobe: the SCLK falling edge occurs (shift-out point).
REQ-015 rise_stb_o  out  1  one-cycle strobe: the SCLK rising edge occurs (sample point).
REQ-016 busy_o  out  1  burst in progress.
REQ-017 done_o  out  1  one-cycle strobe: burst completed normally.

Function
REQ-018 All outputs SHALL be registered; a strobe SHALL be high in the same cycle that sclk_o first shows the new level.
REQ-019 Half-period H SHALL equal div_r+1 cycles; div_r=0 SHALL give H=1 (SCLK = clk_i/2).
REQ-020 cfg_we_i SHALL update div_r only in IDLE; while busy it SHALL be ignored, and the current burst SHALL keep its divisor.
REQ-021 FSM states SHALL be IDLE, LEAD, RUN and TRAIL.
REQ-022 IDLE: sclk_o=1, cs_n_o=1, busy_o=0.
REQ-023 IDLE to LEAD on start_i=1 with nbits_i!=0; nbits_i SHALL be latched at that point.
REQ-024 start_i with nbits_i=0 SHALL be ignored: no state change and no done_o.
REQ-025 start_i while busy SHALL be ignored.
REQ-026 Cycle timing, with start_i sampled at cycle 0:
- Cycle 1: busy_o=1 and cs_n_o=0 (LEAD).
- Cycle 1+H: first fall; state RUN.
- Cycle 1+2kH: k-th rise.
REQ-027 RUN SHALL toggle sclk_o every H cycles, falls and rises alternating, and SHALL count rises.
REQ-028 The N-th rise SHALL move the FSM to TRAIL, with sclk_o held high.
REQ-029 At cycle 1+(2N+1)H the block SHALL set cs_n_o=1, busy_o=0, done_o=1 for one cycle, and return to IDLE.
REQ-030 Each burst SHALL produce exactly N fall strobes and N rise strobes.
REQ-031 abort_i in LEAD, RUN or TRAIL SHALL, in the next cycle:
- return the FSM to IDLE;
- set sclk_o=1 and cs_n_o=1;
- produce no done_o and no strobe.
REQ-032 abort_i in IDLE SHALL have no effect; abort_i together with start_i SHALL cause abort to win.
REQ-033 abort_i in the same cycle as the last TRAIL cycle SHALL cause abort to win (no done_o).
REQ-034 Back-to-back bursts: start_i in the done_o cycle SHALL be ignored; start_i one cycle later SHALL be accepted.

Reset
REQ-035 rst_i SHALL set the following, including mid-burst:
- state=IDLE;
- div_r=DIV_RST;
- bit counter=0 and half-period counter=0;
- sclk_o=1, cs_n_o=1;
- fall_stb_o=0, rise_stb_o=0, busy_o=0, done_o=0.
REQ-036 The first start_i accepted SHALL be one sampled in the cycle after rst_i deasserts.

Structure
REQ-037 Package spi_clk_pkg SHALL hold the state enum, DIV_W, CNT_W and DIV_RST.
REQ-038 Sub-module hp_timer SHALL provide a loadable down-counter that pulses an expiry output every H cycles while enabled.
REQ-039 The FSM, bit counter and output registers SHALL reside in spi_clk_ctrl.

Verification
REQ-040 div=0, N=1, start at cycle 0 -> cs_n_o low at cycle 1, fall at 2, rise at 3, done_o at 4.
REQ-041 div=24, N=8 -> first fall at 26, 8th rise at 401, done_o and cs_n_o high at 426, 8 strobes of each type.
REQ-042 div=24, N=8, abort_i at cycle 200 -> sclk_o=1, cs_n_o=1, busy_o=0 at 201, no done_o, no further strobes.
REQ-043 cfg_we_i with div_i=3 at cycle 100 of a div=24 burst -> burst keeps H=25; the next burst uses H=4.
REQ-044 start_i with nbits_i=0 -> busy_o stays 0 and no done_o; start_i with abort_i in IDLE -> no burst.
REQ-045 rst_i at cycle 150 of a burst -> all outputs at reset values at 151; div_r=24; a new burst works normally.
